alu_seq: RTL and testbench
==========================

# alu_seq

Parametrised, multi-cycle successor to the 4-bit combinational ALU tile: a WIDTH-bit ALU with registered result, persistent C/V/Z/N flag register, multi-bit shifts and shift-add multiply. Operations enter through a valid/ready handshake; single-cycle ops sustain one per clock, while shifts and multiply hold the block busy. It sits between the tile's pin decoder and output mux.

## Interface
- WIDTH, 8, datapath width; power of two, ≥4. SW = clog2(WIDTH).
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  operation request
- in_ready  out  1  block can accept an operation this cycle
- op  in  4  opcode (see Operation)
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B; shift amount = b[SW-1:0]
- out_valid  out  1  one-cycle pulse: y, y_hi and flags are newly updated
- y  out  WIDTH  registered result, held until the next result
- y_hi  out  WIDTH  upper half of the last MUL product, else 0
- flags  out  4  {C,V,Z,N}, registered, persistent

## Operation
- Accept when in_valid & in_ready at a rising edge; operands and op are captured then.
- Opcodes: 0 ADD a+b; 1 ADC a+b+C; 2 SUB a-b; 3 SBC a-b-~C; 4 AND; 5 OR; 6 XOR; 7 NOT a; 8 SHL; 9 SHR (logical); A ASR; B ROL by 1 through C; C ROR by 1 through C; D MUL (unsigned); E PASS b; F CMP (a-b, flags only, y unchanged).
- Arithmetic: computed at WIDTH+1 bits. C = carry out; for SUB/SBC/CMP, C=1 means no borrow. V = signed overflow. Z = (result==0). N = result MSB.
- Logic, NOT, PASS: Z and N are updated, V is cleared, C is unchanged.
- SHL/SHR/ASR by s = b[SW-1:0]: one bit per cycle. C = last bit shifted out. V=0.
- s==0: treated as a single-cycle op; y=a, C unchanged, Z/N from a.
- ROL/ROR: single cycle. The bit shifted out goes to C; the old C is shifted in.
- MUL: shift-add over WIDTH steps. Result is {y_hi,y}. Z over the full 2·WIDTH product. N = product MSB. C = (y_hi!=0). V=0.
- y_hi is cleared by every non-MUL result except CMP.
- FSM:
  - IDLE: in_ready=1. A single-cycle op stays in IDLE. A shift with s>0 loads cnt=s and goes to BUSY. MUL loads cnt=WIDTH and goes to BUSY.
  - BUSY: in_ready=0. One step per cycle, cnt decrements. The step at cnt==1 writes y, y_hi and flags, then returns to IDLE.
- in_valid while BUSY is ignored; the bench must hold the request.
- Reset: y=0, y_hi=0, flags=0, out_valid=0, state=IDLE, cnt=0, in_ready=1. Reset mid-BUSY aborts the operation with no result or flag update.

## Timing
- Single-cycle op accepted at edge k: results are visible and out_valid=1 in the cycle after edge k. Back-to-back acceptance is allowed every cycle. ADC/SBC use C as updated by the immediately preceding op (internal forwarding).
- Shift by s>0 accepted at edge k: steps at edges k+1…k+s. out_valid is high after edge k+s, so latency is s+1. in_ready is low after edge k and high again in the out_valid cycle.
- MUL: latency WIDTH+1 cycles, same in_ready rule.
- out_valid is exactly one cycle per accepted op, including CMP.

## Structure
- Shared package alu_pkg: opcode localparams (OP_ADD…OP_CMP), FSM state encoding (ST_IDLE, ST_BUSY), flag bit indices (FL_C=3, FL_V=2, FL_Z=1, FL_N=0).
- Sub-module alu_comb: a combinational WIDTH-bit adder/logic/rotate unit returning result plus C/V. It is reused by the MUL accumulate step.
- The top level holds the FSM, counter, shift/multiply registers and the flag register.

## Test plan (WIDTH=8)
- Reset → y=0x00, y_hi=0x00, flags=0000, in_ready=1, out_valid=0.
- ADD 0xFF+0x01 → y=0x00, C=1, Z=1; next cycle ADC 0x00+0x00 → y=0x01, C=0, Z=0; ADD 0x7F+0x01 → y=0x80, V=1, N=1.
- SUB 0x05-0x07 → y=0xFE, C=0, N=1; then CMP 0x07,0x07 → Z=1, C=1, y stays 0xFE, out_valid pulses.
- SHL a=0x81, s=3 → out_valid 4 cycles after accept, y=0x08, C=0. SHR a=0x81, s=1 → y=0x40, C=1. ASR a=0x80, s=7 → y=0xFF. ROL a=0x80 with C=1 → y=0x01, C=1.
- MUL 0x10×0x10 → after 9 cycles: y=0x00, y_hi=0x01, C=1, Z=0. in_valid held during BUSY is accepted only after out_valid.
- rst_n low during MUL step 4 → immediate IDLE, all outputs 0. A following ADD 0x02+0x03 → y=0x05 one cycle later.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared opcode, FSM state and flag-index definitions for the sequential ALU
// and its combinational arithmetic/logic unit.
package alu_pkg;

    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_ADC  = 4'h1;
    localparam logic [3:0] OP_SUB  = 4'h2;
    localparam logic [3:0] OP_SBC  = 4'h3;
    localparam logic [3:0] OP_AND  = 4'h4;
    localparam logic [3:0] OP_OR   = 4'h5;
    localparam logic [3:0] OP_XOR  = 4'h6;
    localparam logic [3:0] OP_NOT  = 4'h7;
    localparam logic [3:0] OP_SHL  = 4'h8;
    localparam logic [3:0] OP_SHR  = 4'h9;
    localparam logic [3:0] OP_ASR  = 4'hA;
    localparam logic [3:0] OP_ROL  = 4'hB;
    localparam logic [3:0] OP_ROR  = 4'hC;
    localparam logic [3:0] OP_MUL  = 4'hD;
    localparam logic [3:0] OP_PASS = 4'hE;
    localparam logic [3:0] OP_CMP  = 4'hF;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    // Bit positions inside the packed {C,V,Z,N} flag vector.
    localparam int FL_C = 3;
    localparam int FL_V = 2;
    localparam int FL_Z = 1;
    localparam int FL_N = 0;

endpackage

// File: rtl/alu_comb.sv
// Combinational WIDTH-bit add/subtract, logic and rotate-through-carry unit.
// The sequencer also borrows it as the accumulator adder for multiply steps.
module alu_comb
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic [WIDTH-1:0] result,
    output logic             c_out,
    output logic             v_out
);

    logic             is_sub;
    logic             cin_eff;
    logic [WIDTH-1:0] b_eff;
    logic [WIDTH:0]   sum;

    // Subtraction is a + ~b + carry, so C=1 naturally means "no borrow".
    always_comb begin
        is_sub = (op == OP_SUB) || (op == OP_SBC) || (op == OP_CMP);
        b_eff  = is_sub ? ~b : b;
        case (op)
            OP_ADC, OP_SBC: cin_eff = c_in;
            OP_SUB, OP_CMP: cin_eff = 1'b1;
            default:        cin_eff = 1'b0;
        endcase
        sum = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, cin_eff};
    end

    always_comb begin
        result = a;
        c_out  = c_in;
        v_out  = 1'b0;
        case (op)
            OP_ADD, OP_ADC, OP_SUB, OP_SBC, OP_CMP: begin
                result = sum[WIDTH-1:0];
                c_out  = sum[WIDTH];
                v_out  = (a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_AND:  result = a & b;
            OP_OR:   result = a | b;
            OP_XOR:  result = a ^ b;
            OP_NOT:  result = ~a;
            OP_PASS: result = b;
            OP_ROL: begin
                result = {a[WIDTH-2:0], c_in};
                c_out  = a[WIDTH-1];
            end
            OP_ROR: begin
                result = {c_in, a[WIDTH-1:1]};
                c_out  = a[0];
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/alu_seq.sv
// Multi-cycle WIDTH-bit ALU: registered result and persistent flags, with
// bit-serial shifts and shift-add multiply that hold the block busy.
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    output logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] y_hi,
    output logic [3:0]       flags
);

    localparam int SW    = $clog2(WIDTH);
    localparam int CNT_W = SW + 1;

    state_t           state, state_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic [3:0]       op_q, op_q_nx;
    logic [WIDTH-1:0] work, work_nx;
    logic [WIDTH-1:0] hi, hi_nx;
    logic [WIDTH-1:0] mcand, mcand_nx;
    logic [WIDTH-1:0] y_nx, y_hi_nx;
    logic [3:0]       flags_nx;
    logic             out_valid_nx;

    logic [SW-1:0]    s_amt;
    logic [3:0]       c_op;
    logic [WIDTH-1:0] c_a, c_b, c_res;
    logic             c_cin, c_cout, c_vout;
    logic [WIDTH-1:0] shifted;
    logic             shift_out;
    logic [WIDTH-1:0] hi_step, lo_step;

    assign in_ready = (state == ST_IDLE);
    assign s_amt    = b[SW-1:0];

    // While busy the unit serves as the multiply accumulator; the flag-C input
    // reads the register directly, which already holds the previous op's carry.
    always_comb begin
        c_op  = op;
        c_a   = a;
        c_b   = b;
        c_cin = flags[FL_C];
        if (state == ST_BUSY) begin
            c_op  = OP_ADD;
            c_a   = hi;
            c_b   = work[0] ? mcand : '0;
            c_cin = 1'b0;
        end
    end

    alu_comb #(.WIDTH(WIDTH)) u_comb (
        .op     (c_op),
        .a      (c_a),
        .b      (c_b),
        .c_in   (c_cin),
        .result (c_res),
        .c_out  (c_cout),
        .v_out  (c_vout)
    );

    assign {hi_step, lo_step} = {c_cout, c_res, work[WIDTH-1:1]};

    always_comb begin
        shifted   = work;
        shift_out = 1'b0;
        case (op_q)
            OP_SHL: begin
                shifted   = {work[WIDTH-2:0], 1'b0};
                shift_out = work[WIDTH-1];
            end
            OP_SHR: begin
                shifted   = {1'b0, work[WIDTH-1:1]};
                shift_out = work[0];
            end
            OP_ASR: begin
                shifted   = {work[WIDTH-1], work[WIDTH-1:1]};
                shift_out = work[0];
            end
            default: ;
        endcase
    end

    always_comb begin
        state_nx     = state;
        cnt_nx       = cnt;
        op_q_nx      = op_q;
        work_nx      = work;
        hi_nx        = hi;
        mcand_nx     = mcand;
        y_nx         = y;
        y_hi_nx      = y_hi;
        flags_nx     = flags;
        out_valid_nx = 1'b0;
        case (state)
            ST_IDLE: begin
                if (in_valid) begin
                    op_q_nx = op;
                    case (op)
                        OP_SHL, OP_SHR, OP_ASR: begin
                            if (s_amt == '0) begin
                                y_nx           = a;
                                y_hi_nx        = '0;
                                flags_nx[FL_V] = 1'b0;
                                flags_nx[FL_Z] = (a == '0);
                                flags_nx[FL_N] = a[WIDTH-1];
                                out_valid_nx   = 1'b1;
                            end else begin
                                work_nx  = a;
                                cnt_nx   = {1'b0, s_amt};
                                state_nx = ST_BUSY;
                            end
                        end
                        OP_MUL: begin
                            work_nx  = b;
                            hi_nx    = '0;
                            mcand_nx = a;
                            cnt_nx   = CNT_W'(WIDTH);
                            state_nx = ST_BUSY;
                        end
                        OP_CMP: begin
                            flags_nx     = {c_cout, c_vout, (c_res == '0), c_res[WIDTH-1]};
                            out_valid_nx = 1'b1;
                        end
                        OP_AND, OP_OR, OP_XOR, OP_NOT, OP_PASS: begin
                            y_nx           = c_res;
                            y_hi_nx        = '0;
                            flags_nx[FL_V] = 1'b0;
                            flags_nx[FL_Z] = (c_res == '0);
                            flags_nx[FL_N] = c_res[WIDTH-1];
                            out_valid_nx   = 1'b1;
                        end
                        default: begin
                            y_nx         = c_res;
                            y_hi_nx      = '0;
                            flags_nx     = {c_cout, c_vout, (c_res == '0), c_res[WIDTH-1]};
                            out_valid_nx = 1'b1;
                        end
                    endcase
                end
            end
            ST_BUSY: begin
                cnt_nx = cnt - CNT_W'(1);
                if (op_q == OP_MUL) begin
                    work_nx = lo_step;
                    hi_nx   = hi_step;
                end else begin
                    work_nx = shifted;
                end
                // Final step publishes the result and releases the block.
                if (cnt == CNT_W'(1)) begin
                    state_nx     = ST_IDLE;
                    out_valid_nx = 1'b1;
                    if (op_q == OP_MUL) begin
                        y_nx     = lo_step;
                        y_hi_nx  = hi_step;
                        flags_nx = {(hi_step != '0), 1'b0,
                                    ({hi_step, lo_step} == '0), hi_step[WIDTH-1]};
                    end else begin
                        y_nx     = shifted;
                        y_hi_nx  = '0;
                        flags_nx = {shift_out, 1'b0, (shifted == '0), shifted[WIDTH-1]};
                    end
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            op_q      <= '0;
            work      <= '0;
            hi        <= '0;
            mcand     <= '0;
            y         <= '0;
            y_hi      <= '0;
            flags     <= '0;
            out_valid <= 1'b0;
        end else begin
            state     <= state_nx;
            cnt       <= cnt_nx;
            op_q      <= op_q_nx;
            work      <= work_nx;
            hi        <= hi_nx;
            mcand     <= mcand_nx;
            y         <= y_nx;
            y_hi      <= y_hi_nx;
            flags     <= flags_nx;
            out_valid <= out_valid_nx;
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Randomised scoreboard bench for alu_seq: an integer-arithmetic reference
// model predicts each result and its arrival cycle; a monitor checks them.
module tb_alu_seq;
    import alu_pkg::*;

    localparam int WIDTH = 8;

    logic             clk, rst_n, in_valid, in_ready, out_valid;
    logic [3:0]       op, flags;
    logic [WIDTH-1:0] a, b, y, y_hi;

    typedef struct {
        logic [3:0] op;
        logic [7:0] y;
        logic [7:0] yhi;
        logic [3:0] fl;
        int         cyc;
    } exp_t;

    exp_t       sb[$];
    exp_t       mon_e;
    int         cyc = 0;
    int         total = 0;
    int         bad = 0;
    int         ready_from = 0;
    logic [7:0] m_y, m_yhi;
    logic [3:0] m_fl;

    alu_seq #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .y         (y),
        .y_hi      (y_hi),
        .flags     (flags)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Reference model: plain integer arithmetic on the architectural state.
    task automatic modelOp(input logic [3:0] o, input logic [7:0] av, input logic [7:0] bv,
                           output int lat);
        int ia, ib, sa, sbv, c, s, r, sr, p;
        logic cf, vf;
        logic [7:0] res;
        ia  = int'(av);
        ib  = int'(bv);
        sa  = (ia >= 128) ? ia - 256 : ia;
        sbv = (ib >= 128) ? ib - 256 : ib;
        c   = m_fl[3] ? 1 : 0;
        s   = ib % 8;
        cf  = m_fl[3];
        vf  = 1'b0;
        r   = 0;
        sr  = 0;
        lat = 0;
        res = m_y;
        case (o)
            OP_ADD: begin r = ia + ib;     sr = sa + sbv;     cf = (r > 255); end
            OP_ADC: begin r = ia + ib + c; sr = sa + sbv + c; cf = (r > 255); end
            OP_SUB, OP_CMP: begin r = ia - ib; sr = sa - sbv; cf = (r >= 0); end
            OP_SBC: begin r = ia - ib - (1 - c); sr = sa - sbv - (1 - c); cf = (r >= 0); end
            OP_AND:  r = ia & ib;
            OP_OR:   r = ia | ib;
            OP_XOR:  r = ia ^ ib;
            OP_NOT:  r = 255 - ia;
            OP_PASS: r = ib;
            OP_SHL: begin
                r = (ia << s) & 255;
                if (s > 0) begin cf = ((ia >> (8 - s)) & 1) != 0; lat = s; end
            end
            OP_SHR: begin
                r = ia >> s;
                if (s > 0) begin cf = ((ia >> (s - 1)) & 1) != 0; lat = s; end
            end
            OP_ASR: begin
                r = (sa >>> s) & 255;
                if (s > 0) begin cf = ((ia >> (s - 1)) & 1) != 0; lat = s; end
            end
            OP_ROL: begin r = ((ia << 1) | c) & 255; cf = (ia >= 128); end
            OP_ROR: begin r = (ia >> 1) | (c * 128); cf = (ia % 2) == 1; end
            default: ;
        endcase
        if (o inside {OP_ADD, OP_ADC, OP_SUB, OP_SBC, OP_CMP})
            vf = (sr > 127) || (sr < -128);
        res = r[7:0];
        if (o == OP_MUL) begin
            p     = ia * ib;
            m_y   = p[7:0];
            m_yhi = p[15:8];
            m_fl  = {(p[15:8] != 8'h00), 1'b0, (p == 0), p[15]};
            lat   = 8;
        end else begin
            m_fl = {cf, vf, (res == 8'h00), res[7]};
            if (o != OP_CMP) begin
                m_y   = res;
                m_yhi = 8'h00;
            end
        end
    endtask

    // Holds the request until the model says the block is free, then records
    // the predicted result and the cycle in which out_valid must appear.
    task automatic applyStimulus(input logic [3:0] o, input logic [7:0] av, input logic [7:0] bv);
        int   lat;
        exp_t e;
        op       = o;
        a        = av;
        b        = bv;
        in_valid = 1'b1;
        while (cyc < ready_from) begin
            checkOutput("in_ready_busy", 32'(in_ready), 32'd0);
            @(posedge clk);
            #1;
        end
        checkOutput("in_ready_idle", 32'(in_ready), 32'd1);
        modelOp(o, av, bv, lat);
        e.op  = o;
        e.y   = m_y;
        e.yhi = m_yhi;
        e.fl  = m_fl;
        e.cyc = cyc + 1 + lat;
        sb.push_back(e);
        ready_from = cyc + 1 + lat;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("[TB] FAIL unexpected_out_valid actual=1 expected=0 at cycle %0d", cyc);
            end else begin
                mon_e = sb.pop_front();
                checkOutput($sformatf("y_op%0h", mon_e.op), 32'(y), 32'(mon_e.y));
                checkOutput($sformatf("y_hi_op%0h", mon_e.op), 32'(y_hi), 32'(mon_e.yhi));
                checkOutput($sformatf("flags_op%0h", mon_e.op), 32'(flags), 32'(mon_e.fl));
                checkOutput($sformatf("cycle_op%0h", mon_e.op), 32'(cyc), 32'(mon_e.cyc));
            end
        end
    end

    task automatic checkResetState(input string tag);
        checkOutput({tag, "_y"}, 32'(y), 32'd0);
        checkOutput({tag, "_y_hi"}, 32'(y_hi), 32'd0);
        checkOutput({tag, "_flags"}, 32'(flags), 32'd0);
        checkOutput({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        checkOutput({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    endtask

    // MUL 0x10*0x10 interrupted by reset before its fourth step.
    task automatic abortMul();
        while (cyc < ready_from) begin
            @(posedge clk);
            #1;
        end
        op       = OP_MUL;
        a        = 8'h10;
        b        = 8'h10;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("in_ready_mid_mul", 32'(in_ready), 32'd0);
        rst_n = 1'b0;
        #1;
        checkResetState("abort");
        m_y   = 8'h00;
        m_yhi = 8'h00;
        m_fl  = 4'h0;
        @(posedge clk);
        #1;
        rst_n      = 1'b1;
        ready_from = cyc;
    endtask

    logic [3:0] r_op;
    logic [7:0] r_a, r_b;

    initial begin
        in_valid = 1'b0;
        op       = 4'h0;
        a        = 8'h00;
        b        = 8'h00;
        m_y      = 8'h00;
        m_yhi    = 8'h00;
        m_fl     = 4'h0;
        rst_n    = 1'b1;
        #1 rst_n = 1'b0;
        #2;
        checkResetState("reset");
        repeat (2) @(posedge clk);
        #1;
        rst_n      = 1'b1;
        ready_from = cyc;

        applyStimulus(OP_ADD, 8'hFF, 8'h01);
        applyStimulus(OP_ADC, 8'h00, 8'h00);
        applyStimulus(OP_ADD, 8'h7F, 8'h01);
        applyStimulus(OP_SUB, 8'h05, 8'h07);
        applyStimulus(OP_CMP, 8'h07, 8'h07);
        applyStimulus(OP_SHL, 8'h81, 8'h03);
        applyStimulus(OP_SHR, 8'h81, 8'h01);
        applyStimulus(OP_ASR, 8'h80, 8'h07);
        applyStimulus(OP_ADD, 8'hFF, 8'h01);
        applyStimulus(OP_ROL, 8'h80, 8'h00);
        applyStimulus(OP_MUL, 8'h10, 8'h10);
        applyStimulus(OP_ADD, 8'h01, 8'h01);
        applyStimulus(OP_MUL, 8'hFF, 8'hFF);
        applyStimulus(OP_SBC, 8'h00, 8'h01);
        applyStimulus(OP_SHL, 8'h55, 8'h08);

        abortMul();
        applyStimulus(OP_ADD, 8'h02, 8'h03);

        for (int i = 0; i < 300; i++) begin
            r_op = 4'($urandom_range(0, 15));
            r_a  = 8'($urandom);
            r_b  = 8'($urandom);
            if (($urandom % 8) == 0) r_a = 8'h00;
            if (($urandom % 8) == 0) r_b = (($urandom % 2) == 0) ? 8'h00 : 8'hFF;
            applyStimulus(r_op, r_a, r_b);
            if (($urandom % 4) == 0) begin
                @(posedge clk);
                #1;
            end
        end

        for (int i = 0; i < 200 && sb.size() != 0; i++) @(posedge clk);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("scoreboard_drain", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
